// File: rtl/fc_stream_pkg.sv
// fc_stream_pkg
// Shared definitions for the fully connected layer stream driver.
//   fc_drv_state_t : driver FSM states (IDLE, SEND, RECV, DONE)
//   GAP_CNT_W      : width of the rx gap counter (RX_GAP must fit in it)
//   addr_w()       : index width for a buffer of a given depth, never below 1
package fc_stream_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RECV = 2'd2,
        DONE = 2'd3
    } fc_drv_state_t;

    localparam int GAP_CNT_W = 8;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fc_stream_regfile.sv
// fc_stream_regfile
// Small word buffer with an asynchronous active-low clear, one synchronous
// write port and one read port. REG_READ selects a combinational read
// (REG_READ=0) or a one-cycle registered read (REG_READ=1).
// Ports:
//   clk      : rising-edge clock
//   reset    : asynchronous clear, active low; all words and the read register go to 0
//   wr_en    : write strobe; writes to addresses >= DEPTH are dropped
//   wr_addr  : write index
//   wr_data  : write word
//   rd_addr  : read index
//   rd_data  : read word (combinational or registered, see REG_READ)
module fc_stream_regfile
    import fc_stream_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int AW       = addr_w(DEPTH),
    parameter bit REG_READ = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    // Storage is sized to the full address space so every index is in range;
    // slots at DEPTH and above are never written and therefore read as 0.
    localparam int SLOTS = 1 << AW;

    logic [WIDTH-1:0] mem [SLOTS];
    logic             wr_ok;

    assign wr_ok = wr_en && (32'(wr_addr) < DEPTH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SLOTS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    generate
        if (REG_READ) begin : g_reg_read
            // Reads the pre-write contents, so a same-cycle write returns the old word.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    rd_data <= '0;
                end else begin
                    rd_data <= mem[rd_addr];
                end
            end
        end else begin : g_comb_read
            assign rd_data = mem[rd_addr];
        end
    endgenerate

endmodule

// File: rtl/fc_stream_driver.sv
// fc_stream_driver
// Host-side driver for a generated fully connected layer. The host loads an
// N-word vector, pulses start; the block streams the vector out on tx_*,
// collects M result words on rx_*, stores them for host readback and pulses done.
// Ports:
//   clk, reset           : clock, asynchronous active-low reset
//   vec_wr_en/addr/data  : host vector writes (honoured only in IDLE)
//   start                : begin a run (sampled only in IDLE)
//   busy                 : high while sending or receiving
//   done                 : one-cycle pulse after the last result is stored
//   res_rd_addr/data     : registered result readback
//   tx_valid/ready/data  : stream to the layer input
//   rx_valid/ready/data  : stream from the layer output
module fc_stream_driver
    import fc_stream_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int N      = 10,
    parameter int M      = 8,
    parameter int RX_GAP = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   vec_wr_en,
    input  logic [addr_w(N)-1:0]   vec_wr_addr,
    input  logic [WIDTH-1:0]       vec_wr_data,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    input  logic [addr_w(M)-1:0]   res_rd_addr,
    output logic [WIDTH-1:0]       res_rd_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic [WIDTH-1:0]       tx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    input  logic [WIDTH-1:0]       rx_data
);

    localparam int VEC_AW = addr_w(N);
    localparam int RES_AW = addr_w(M);

    fc_drv_state_t          state;
    logic [VEC_AW-1:0]      tx_cnt;
    logic [RES_AW-1:0]      rx_cnt;
    logic [GAP_CNT_W-1:0]   gap_cnt;
    logic [WIDTH-1:0]       vec_rd;
    logic                   vec_we;
    logic                   rx_fire;
    logic                   tx_fire;

    // Host writes only land while idle; a run in flight sees a frozen vector.
    assign vec_we  = vec_wr_en && (state == IDLE);
    assign tx_fire = tx_valid && tx_ready;
    assign rx_fire = (state == RECV) && rx_valid && rx_ready;

    fc_stream_regfile #(
        .WIDTH    (WIDTH),
        .DEPTH    (N),
        .AW       (VEC_AW),
        .REG_READ (1'b0)
    ) u_vec (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (vec_we),
        .wr_addr (vec_wr_addr),
        .wr_data (vec_wr_data),
        .rd_addr (tx_cnt),
        .rd_data (vec_rd)
    );

    fc_stream_regfile #(
        .WIDTH    (WIDTH),
        .DEPTH    (M),
        .AW       (RES_AW),
        .REG_READ (1'b1)
    ) u_res (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (rx_fire),
        .wr_addr (rx_cnt),
        .wr_data (rx_data),
        .rd_addr (res_rd_addr),
        .rd_data (res_rd_data)
    );

    // tx_cnt only moves on a transfer, so the word is held stable under backpressure.
    assign tx_data = tx_valid ? vec_rd : '0;

    // Run sequencer. Handshake outputs are registered so they change only
    // on clock edges. After each accepted result rx_ready is held low for
    // RX_GAP cycles so a producer that registers ready cannot be counted twice.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            tx_cnt   <= '0;
            rx_cnt   <= '0;
            gap_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            tx_valid <= 1'b0;
            rx_ready <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= SEND;
                        tx_cnt   <= '0;
                        busy     <= 1'b1;
                        tx_valid <= 1'b1;
                    end
                end
                SEND: begin
                    if (tx_fire) begin
                        if (tx_cnt == VEC_AW'(N - 1)) begin
                            state    <= RECV;
                            tx_valid <= 1'b0;
                            rx_ready <= 1'b1;
                            rx_cnt   <= '0;
                            gap_cnt  <= '0;
                        end else begin
                            tx_cnt <= tx_cnt + 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (rx_fire) begin
                        if (rx_cnt == RES_AW'(M - 1)) begin
                            state    <= DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            rx_ready <= 1'b0;
                        end else begin
                            rx_cnt <= rx_cnt + 1'b1;
                            if (RX_GAP > 0) begin
                                rx_ready <= 1'b0;
                                gap_cnt  <= GAP_CNT_W'(RX_GAP);
                            end
                        end
                    end else if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 1'b1;
                        if (gap_cnt == GAP_CNT_W'(1)) begin
                            rx_ready <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc_stream_driver.sv
// tb_fc_stream_driver
// Self-checking bench for fc_stream_driver. A run-level reference model
// (phase plus words sent/received plus remaining gap cycles) predicts every
// output on every cycle; directed scenarios add hand-computed expectations.
`timescale 1ns/1ps
module tb_fc_stream_driver;

    localparam int WIDTH  = 16;
    localparam int N      = 10;
    localparam int M      = 8;
    localparam int RX_GAP = 2;
    localparam int VA     = (N > 1) ? $clog2(N) : 1;
    localparam int RA     = (M > 1) ? $clog2(M) : 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             vec_wr_en = 1'b0;
    logic [VA-1:0]    vec_wr_addr = '0;
    logic [WIDTH-1:0] vec_wr_data = '0;
    logic             start = 1'b0;
    logic             busy;
    logic             done;
    logic [RA-1:0]    res_rd_addr = '0;
    logic [WIDTH-1:0] res_rd_data;
    logic             tx_valid;
    logic             tx_ready = 1'b0;
    logic [WIDTH-1:0] tx_data;
    logic             rx_valid = 1'b0;
    logic             rx_ready;
    logic [WIDTH-1:0] rx_data = '0;

    int total = 0;
    int bad   = 0;

    fc_stream_driver #(
        .WIDTH  (WIDTH),
        .N      (N),
        .M      (M),
        .RX_GAP (RX_GAP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .vec_wr_en   (vec_wr_en),
        .vec_wr_addr (vec_wr_addr),
        .vec_wr_data (vec_wr_data),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .res_rd_addr (res_rd_addr),
        .res_rd_data (res_rd_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 sending, 2 receiving, 3 done pulse.
    int               m_phase = 0;
    int               m_sent  = 0;
    int               m_rcvd  = 0;
    int               m_gap   = 0;
    logic [WIDTH-1:0] m_vec [N];
    logic [WIDTH-1:0] m_res [M];
    logic [WIDTH-1:0] m_rd  = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase <= 0;
            m_sent  <= 0;
            m_rcvd  <= 0;
            m_gap   <= 0;
            m_rd    <= '0;
            for (int i = 0; i < N; i++) m_vec[i] <= '0;
            for (int i = 0; i < M; i++) m_res[i] <= '0;
        end else begin
            m_rd <= (int'(res_rd_addr) < M) ? m_res[res_rd_addr] : '0;
            case (m_phase)
                0: begin
                    if (vec_wr_en && int'(vec_wr_addr) < N) m_vec[vec_wr_addr] <= vec_wr_data;
                    if (start) begin
                        m_phase <= 1;
                        m_sent  <= 0;
                    end
                end
                1: begin
                    if (tx_ready) begin
                        m_sent <= m_sent + 1;
                        if (m_sent == N - 1) begin
                            m_phase <= 2;
                            m_rcvd  <= 0;
                            m_gap   <= 0;
                        end
                    end
                end
                2: begin
                    if (m_gap > 0) begin
                        m_gap <= m_gap - 1;
                    end else if (rx_valid) begin
                        m_res[m_rcvd] <= rx_data;
                        m_rcvd        <= m_rcvd + 1;
                        m_gap         <= RX_GAP;
                        if (m_rcvd == M - 1) m_phase <= 3;
                    end
                end
                default: m_phase <= 0;
            endcase
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        check_output("busy",        busy,        32'(m_phase == 1 || m_phase == 2));
        check_output("done",        done,        32'(m_phase == 3));
        check_output("tx_valid",    tx_valid,    32'(m_phase == 1));
        check_output("rx_ready",    rx_ready,    32'(m_phase == 2 && m_gap == 0));
        check_output("res_rd_data", res_rd_data, 32'(m_rd));
        if (m_phase == 1) check_output("tx_data", tx_data, 32'(m_vec[m_sent]));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_vec(input int addr, input int data);
        vec_wr_en   = 1'b1;
        vec_wr_addr = VA'(addr);
        vec_wr_data = WIDTH'(data);
        tick();
        vec_wr_en   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic apply_stimulus(input int cycles, input bit allow_host);
        for (int c = 0; c < cycles; c++) begin
            tx_ready    = ($urandom_range(0, 3) != 0);
            rx_valid    = 1'($urandom_range(0, 1));
            rx_data     = WIDTH'($urandom);
            res_rd_addr = RA'($urandom_range(0, M - 1));
            if (allow_host) begin
                start       = ($urandom_range(0, 9) == 0);
                vec_wr_en   = 1'($urandom_range(0, 1));
                vec_wr_addr = VA'($urandom_range(0, (1 << VA) - 1));
                vec_wr_data = WIDTH'($urandom);
                reset       = ($urandom_range(0, 399) != 0);
            end
            tick();
        end
        start     = 1'b0;
        vec_wr_en = 1'b0;
        reset     = 1'b1;
    endtask

    // Drives random handshakes until the model returns to idle, within a budget.
    task automatic finish_run(input int budget);
        for (int c = 0; c < budget && m_phase != 0; c++) begin
            apply_stimulus(1, 1'b0);
        end
        check_output("run_end_busy", busy, 0);
    endtask

    int             acc_cycle [$];
    logic [WIDTH-1:0] sent_q  [$];
    int             done_cnt;
    int             vcnt;
    bit             acc;

    initial begin
        $display("[TB] start");
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        check_output("rst_busy",     busy,        0);
        check_output("rst_done",     done,        0);
        check_output("rst_tx_valid", tx_valid,    0);
        check_output("rst_rx_ready", rx_ready,    0);
        check_output("rst_tx_data",  tx_data,     0);
        check_output("rst_res_data", res_rd_data, 0);
        tick();
        reset = 1'b1;
        tick();

        // Back-to-back send of 1..10; an out-of-range write is dropped.
        for (int i = 0; i < N; i++) write_vec(i, i + 1);
        write_vec(12, 55);
        tx_ready = 1'b1;
        pulse_start();
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            check_output("t1_tx_valid", tx_valid, 1);
            check_output("t1_tx_data",  tx_data,  k + 1);
        end
        @(negedge clk);
        check_output("t1_tx_valid_end", tx_valid, 0);
        check_output("t1_rx_ready_end", rx_ready, 1);
        check_output("t1_busy_end",     busy,     1);

        // Receive 100..107 with rx_valid held high.
        rx_valid = 1'b1;
        rx_data  = WIDTH'(100);
        done_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            acc = rx_valid && rx_ready;
            if (acc) acc_cycle.push_back(c);
            if (done) done_cnt++;
            @(posedge clk);
            #1;
            if (acc) rx_data = rx_data + 1'b1;
            @(negedge clk);
        end
        rx_valid = 1'b0;
        check_output("t3_accepts", acc_cycle.size(), M);
        for (int i = 1; i < acc_cycle.size(); i++)
            check_output("t3_spacing", acc_cycle[i] - acc_cycle[i-1], RX_GAP + 1);
        check_output("t3_done_pulses", done_cnt, 1);
        for (int i = 0; i < M; i++) begin
            res_rd_addr = RA'(i);
            @(posedge clk);
            @(negedge clk);
            check_output("t3_readback", res_rd_data, 100 + i);
        end

        // Backpressured send with start and a vec write attempted while busy.
        tick();
        tx_ready = 1'b0;
        pulse_start();
        vcnt = 0;
        for (int c = 0; c < 30; c++) begin
            tx_ready    = (c % 2 == 1);
            start       = (c == 3);
            vec_wr_en   = (c == 3);
            vec_wr_addr = '0;
            vec_wr_data = WIDTH'(99);
            @(negedge clk);
            if (tx_valid) vcnt++;
            if (tx_valid && tx_ready) sent_q.push_back(tx_data);
            tick();
        end
        start     = 1'b0;
        vec_wr_en = 1'b0;
        check_output("t2_send_cycles", vcnt, 2 * N);
        check_output("t2_word_count", sent_q.size(), N);
        for (int k = 0; k < sent_q.size(); k++) check_output("t2_word", sent_q[k], k + 1);
        finish_run(300);
        tx_ready = 1'b1;
        pulse_start();
        @(negedge clk);
        check_output("t4_vec0_kept", tx_data, 1);
        finish_run(400);

        // Reset after four transfers, then reload all but word 0.
        tx_ready = 1'b1;
        pulse_start();
        repeat (4) tick();
        reset = 1'b0;
        #1;
        check_output("t5_busy",     busy,     0);
        check_output("t5_tx_valid", tx_valid, 0);
        check_output("t5_rx_ready", rx_ready, 0);
        check_output("t5_tx_data",  tx_data,  0);
        tick();
        reset = 1'b1;
        tick();
        for (int i = 1; i < N; i++) write_vec(i, 200 + i);
        tx_ready = 1'b1;
        pulse_start();
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            check_output("t5_data", tx_data, (k == 0) ? 0 : 200 + k);
        end
        finish_run(400);

        // Random runs with fresh vectors.
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < N; i++) write_vec(i, int'($urandom_range(0, 65535)));
            tx_ready = 1'b0;
            pulse_start();
            finish_run(500);
        end

        // Fully random traffic including host writes, stray starts and resets.
        apply_stimulus(3000, 1'b1);
        finish_run(500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
